// File: rtl/sim_watchdog_if.sv
// sim_watchdog_if: channel, error and status signals between the bench and the watchdog
interface sim_watchdog_if #(
  parameter int NCH   = 8,
  parameter int NERR  = 3,
  parameter int CNT_W = 32
);
  logic [NCH-1:0]   halt;
  logic [NCH-1:0]   commit;
  logic [NERR-1:0]  error;
  logic [NERR-1:0]  err_en;
  logic             finish;
  logic [2:0]       status;
  logic [7:0]       src_idx;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] commits;
  modport master (output halt, commit, error, err_en, input finish, status, src_idx, cycles, commits);
  modport slave (input halt, commit, error, err_en, output finish, status, src_idx, cycles, commits);
endinterface

// File: rtl/sim_watchdog.sv
// sim_watchdog: end-of-simulation controller for halt, timeout, error-with-drain and deadlock
module sim_watchdog #(
  parameter int NCH          = 8,
  parameter int NERR         = 3,
  parameter int TIMEOUT      = 10000000,
  parameter int STALL_LIMIT  = 100000,
  parameter int DRAIN_CYCLES = 5,
  parameter int CNT_W        = 32
) (
  input logic clk,
  input logic rst,
  sim_watchdog_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] stall;
  logic [31:0] dcnt;
  logic [2:0] status_nx;
  logic [7:0] idx_nx;
  logic [CNT_W:0] sum;
  logic [NERR-1:0] err_hit;
  logic any_commit, tout_hit, dead_hit;
  function automatic logic [7:0] lowest(input logic [255:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 255; i >= 0; i--) if (v[i]) r = 8'(i);
    return r;
  endfunction
  // Exit priority: halt, timeout, enabled error, deadlock; DRAIN counts down to DONE
  always_comb begin
    sum = {1'b0, bus.commits};
    for (int i = 0; i < NCH; i++) sum = sum + {{CNT_W{1'b0}}, bus.commit[i]};
    any_commit = |bus.commit;
    err_hit = bus.error & bus.err_en;
    tout_hit = TIMEOUT != 0 && bus.cycles == CNT_W'(TIMEOUT - 1);
    dead_hit = STALL_LIMIT != 0 && !any_commit && stall == CNT_W'(STALL_LIMIT - 1);
    state_nx = state;
    status_nx = bus.status;
    idx_nx = bus.src_idx;
    if (state == RUN) begin
      if (|bus.halt) begin
        state_nx = DONE;
        status_nx = 3'd1;
        idx_nx = lowest(256'(bus.halt));
      end else if (tout_hit) begin
        state_nx = DONE;
        status_nx = 3'd2;
      end else if (|err_hit) begin
        state_nx = DRAIN_CYCLES > 1 ? DRAIN : DONE;
        status_nx = 3'd3;
        idx_nx = lowest(256'(err_hit));
      end else if (dead_hit) begin
        state_nx = DONE;
        status_nx = 3'd4;
      end
    end else if (state == DRAIN && dcnt == 32'd1) state_nx = DONE;
  end
  // State, counters and registered outputs; counters only advance in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      stall <= '0;
      dcnt <= '0;
      bus.cycles <= '0;
      bus.commits <= '0;
      bus.status <= '0;
      bus.src_idx <= '0;
      bus.finish <= 1'b0;
    end else begin
      state <= state_nx;
      bus.status <= status_nx;
      bus.src_idx <= idx_nx;
      bus.finish <= state_nx == DONE;
      if (state == RUN) begin
        bus.cycles <= bus.cycles + 1'b1;
        bus.commits <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        stall <= any_commit ? '0 : stall + 1'b1;
        dcnt <= 32'(DRAIN_CYCLES - 1);
      end else if (state == DRAIN) dcnt <= dcnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_sim_watchdog.sv
// tb_sim_watchdog: directed checks of halt, timeout, error drain, deadlock and saturation
module tb_sim_watchdog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  sim_watchdog_if #(.NCH(8), .NERR(3), .CNT_W(32)) a_if ();
  sim_watchdog_if #(.NCH(8), .NERR(3), .CNT_W(32)) b_if ();
  sim_watchdog_if #(.NCH(8), .NERR(3), .CNT_W(8)) c_if ();
  sim_watchdog #(.NCH(8), .NERR(3), .TIMEOUT(100), .STALL_LIMIT(0), .DRAIN_CYCLES(5), .CNT_W(32))
    u_a (.clk(clk), .rst(rst), .bus(a_if));
  sim_watchdog #(.NCH(8), .NERR(3), .TIMEOUT(0), .STALL_LIMIT(16), .DRAIN_CYCLES(5), .CNT_W(32))
    u_b (.clk(clk), .rst(rst), .bus(b_if));
  sim_watchdog #(.NCH(8), .NERR(3), .TIMEOUT(0), .STALL_LIMIT(0), .DRAIN_CYCLES(0), .CNT_W(8))
    u_c (.clk(clk), .rst(rst), .bus(c_if));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask
  initial begin
    {a_if.halt, a_if.commit, a_if.error, a_if.err_en} = '0;
    {b_if.halt, b_if.commit, b_if.error, b_if.err_en} = '0;
    {c_if.halt, c_if.commit, c_if.error, c_if.err_en} = '0;
    do_reset();
    chk("rst_finish", a_if.finish, 0);
    chk("rst_status", a_if.status, 0);
    chk("rst_src", a_if.src_idx, 0);
    chk("rst_cycles", a_if.cycles, 0);
    chk("rst_commits", a_if.commits, 0);
    step_to(50);
    chk("halt_pre", a_if.finish, 0);
    a_if.halt = 8'b0010_0100;
    step_to(51);
    a_if.halt = '0;
    chk("halt_finish", a_if.finish, 1);
    chk("halt_status", a_if.status, 1);
    chk("halt_src", a_if.src_idx, 2);
    chk("halt_cycles", a_if.cycles, 51);
    step_to(55);
    chk("halt_frozen", a_if.cycles, 51);
    chk("halt_sticky", a_if.finish, 1);
    do_reset();
    while (cyc < 100) begin
      if (cyc == 99) chk("tout_pre", a_if.finish, 0);
      a_if.commit = (cyc % 2 == 1) ? 8'h01 : 8'h00;
      step_to(cyc + 1);
    end
    a_if.commit = '0;
    chk("tout_finish", a_if.finish, 1);
    chk("tout_status", a_if.status, 2);
    chk("tout_cycles", a_if.cycles, 100);
    chk("tout_commits", a_if.commits, 50);
    do_reset();
    a_if.err_en = 3'b110;
    step_to(20);
    a_if.error = 3'b011;
    step_to(21);
    a_if.error = '0;
    chk("err_status", a_if.status, 3);
    chk("err_src", a_if.src_idx, 1);
    chk("err_nofin", a_if.finish, 0);
    step_to(22);
    a_if.halt = 8'h01;
    step_to(23);
    a_if.halt = '0;
    step_to(24);
    chk("drain_t24", a_if.finish, 0);
    step_to(25);
    chk("drain_fin", a_if.finish, 1);
    chk("drain_status", a_if.status, 3);
    chk("drain_src", a_if.src_idx, 1);
    chk("drain_cycles", a_if.cycles, 21);
    do_reset();
    a_if.err_en = 3'b100;
    step_to(20);
    a_if.error = 3'b011;
    step_to(40);
    chk("mask_status", a_if.status, 0);
    chk("mask_finish", a_if.finish, 0);
    chk("mask_cycles", a_if.cycles, 40);
    a_if.error = '0;
    do_reset();
    step_to(99);
    a_if.halt = 8'h80;
    a_if.error = 3'b100;
    step_to(100);
    a_if.halt = '0;
    a_if.error = '0;
    chk("tie_status", a_if.status, 1);
    chk("tie_src", a_if.src_idx, 7);
    chk("tie_finish", a_if.finish, 1);
    do_reset();
    a_if.err_en = 3'b110;
    step_to(5);
    a_if.error = 3'b010;
    step_to(6);
    a_if.error = '0;
    chk("mid_status", a_if.status, 3);
    step_to(7);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_finish", a_if.finish, 0);
    chk("mid_rst_status", a_if.status, 0);
    chk("mid_rst_src", a_if.src_idx, 0);
    chk("mid_rst_cycles", a_if.cycles, 0);
    rst = 1'b0;
    cyc = 0;
    step_to(30);
    chk("mid_run_cycles", a_if.cycles, 30);
    chk("mid_run_finish", a_if.finish, 0);
    a_if.halt = 8'h01;
    step_to(31);
    a_if.halt = '0;
    chk("mid_halt_status", a_if.status, 1);
    chk("mid_halt_src", a_if.src_idx, 0);
    do_reset();
    b_if.commit = 8'h03;
    step_to(10);
    b_if.commit = '0;
    step_to(25);
    chk("dead_pre", b_if.finish, 0);
    step_to(26);
    chk("dead_finish", b_if.finish, 1);
    chk("dead_status", b_if.status, 4);
    chk("dead_cycles", b_if.cycles, 26);
    chk("dead_commits", b_if.commits, 20);
    do_reset();
    b_if.commit = 8'h01;
    step_to(10);
    b_if.commit = '0;
    step_to(19);
    b_if.commit = 8'h01;
    step_to(20);
    b_if.commit = '0;
    step_to(35);
    chk("dead2_pre", b_if.finish, 0);
    step_to(36);
    chk("dead2_finish", b_if.finish, 1);
    chk("dead2_status", b_if.status, 4);
    chk("dead2_commits", b_if.commits, 11);
    do_reset();
    c_if.commit = 8'hFF;
    step_to(31);
    chk("sat_31", c_if.commits, 248);
    step_to(32);
    chk("sat_32", c_if.commits, 255);
    step_to(40);
    chk("sat_40", c_if.commits, 255);
    chk("sat_cycles", c_if.cycles, 40);
    c_if.err_en = 3'b001;
    c_if.error = 3'b001;
    step_to(41);
    c_if.error = '0;
    c_if.commit = '0;
    chk("d0_finish", c_if.finish, 1);
    chk("d0_status", c_if.status, 3);
    chk("d0_commits", c_if.commits, 255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
